// File: rtl/ctrl_pkg.sv
// Shared constants and types for the picoRISC hardwired controller.
// Step counter geometry plus the next-step select encoding.
package ctrl_pkg;

    localparam int STEP_W = 8;
    localparam int T_W = 2 ** STEP_W;
    localparam logic [STEP_W-1:0] RESET_STEP = 8'd0;
    localparam logic [STEP_W-1:0] ERR_STEP = 8'd255;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_ERR,
        SEL_DISP,
        SEL_TARGET,
        SEL_INC
    } stepSel_t;

endpackage

// File: rtl/step_sequencer_if.sv
// Strobe/status bundle between the step sequencer and the translator.
// The translator side is the master; the sequencer is the slave.
interface step_sequencer_if;
    import ctrl_pkg::*;

    logic              br_uncnd;
    logic              br_cond;
    logic              cond;
    logic              br_wait;
    logic              fc;
    logic              br_disp;
    logic [STEP_W-1:0] target;
    logic [STEP_W-1:0] disp_addr;
    logic              halt;
    logic [T_W-1:0]    T;
    logic [STEP_W-1:0] step;
    logic              halted;
    logic              timeout;

    modport master (
        output br_uncnd, br_cond, cond, br_wait, fc,
        output br_disp, target, disp_addr, halt,
        input  T, step, halted, timeout
    );

    modport slave (
        input  br_uncnd, br_cond, cond, br_wait, fc,
        input  br_disp, target, disp_addr, halt,
        output T, step, halted, timeout
    );

endinterface

// File: rtl/step_decode.sv
// Binary step to one-hot timing vector; a low enable blanks the vector.
module step_decode
    import ctrl_pkg::*;
(
    input  logic [STEP_W-1:0] step,
    input  logic              en,
    output logic [T_W-1:0]    onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[step] = 1'b1;
    end

endmodule

// File: rtl/step_sequencer.sv
// Control-unit step counter: priority next-step mux, wait timeout and halt.
// All outputs are registered; T is decoded from the next step before the flop.
module step_sequencer
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input logic clk,
    input logic rst,
    step_sequencer_if.slave bus
);

    localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    logic [STEP_W-1:0] stepQ, stepNext;
    logic [WCNT_W-1:0] wcntQ, wcntNext;
    logic [T_W-1:0]    tQ, tNext;
    logic              haltedQ, timeoutQ;
    logic              timeoutNext;
    logic              waitHit;
    stepSel_t          sel;

    assign waitHit = bus.br_wait & ~bus.fc;

    always_comb begin
        sel = SEL_INC;
        wcntNext = '0;
        timeoutNext = 1'b0;
        if (bus.halt) begin
            sel = SEL_HOLD;
            wcntNext = wcntQ;
        end else if (waitHit && wcntQ == WCNT_LAST) begin
            sel = SEL_ERR;
            timeoutNext = 1'b1;
        end else if (waitHit) begin
            sel = SEL_HOLD;
            wcntNext = wcntQ + WCNT_W'(1);
        end else if (bus.br_disp) begin
            sel = SEL_DISP;
        end else if (bus.br_uncnd || (bus.br_cond && bus.cond)) begin
            sel = SEL_TARGET;
        end
    end

    always_comb begin
        stepNext = stepQ;
        unique case (sel)
            SEL_HOLD:   stepNext = stepQ;
            SEL_ERR:    stepNext = ERR_STEP;
            SEL_DISP:   stepNext = bus.disp_addr;
            SEL_TARGET: stepNext = bus.target;
            SEL_INC:    stepNext = stepQ + STEP_W'(1);
        endcase
    end

    step_decode uDecode (
        .step   (stepNext),
        .en     (~bus.halt),
        .onehot (tNext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stepQ    <= RESET_STEP;
            wcntQ    <= '0;
            tQ       <= T_W'(1) << RESET_STEP;
            haltedQ  <= 1'b0;
            timeoutQ <= 1'b0;
        end else begin
            stepQ    <= stepNext;
            wcntQ    <= wcntNext;
            tQ       <= tNext;
            haltedQ  <= bus.halt;
            timeoutQ <= timeoutNext;
        end
    end

    assign bus.step    = stepQ;
    assign bus.T       = tQ;
    assign bus.halted  = haltedQ;
    assign bus.timeout = timeoutQ;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: reference model feeding a scoreboard,
// a table of single-step priority vectors, and directed wait/halt sequences.
module tb_step_sequencer;
    import ctrl_pkg::*;

    localparam int TO = 64;

    typedef struct {
        int step;
        int halted;
        int timeout;
    } exp_t;

    typedef struct {
        bit   bw, fc, bd, bu, bc, cn;
        logic [7:0] tgt, dsp, from, exp;
    } vec_t;

    logic clk, rst;
    step_sequencer_if bus ();
    step_sequencer_if bus1 ();

    step_sequencer #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    step_sequencer #(.MEM_TIMEOUT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus1.br_uncnd  = bus.br_uncnd;
    assign bus1.br_cond   = bus.br_cond;
    assign bus1.cond      = bus.cond;
    assign bus1.br_wait   = bus.br_wait;
    assign bus1.fc        = bus.fc;
    assign bus1.br_disp   = bus.br_disp;
    assign bus1.target    = bus.target;
    assign bus1.disp_addr = bus.disp_addr;
    assign bus1.halt      = bus.halt;

    int nChecks = 0;
    int nPass = 0;
    int mStep, mWcnt, mHalted, mTimeout;
    exp_t sb[$];
    vec_t vecs[9];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string nm, int act, int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chkT(string nm, logic [T_W-1:0] act, logic [T_W-1:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic clearIn();
        bus.br_uncnd = 0; bus.br_cond = 0; bus.cond = 0;
        bus.br_wait = 0; bus.fc = 0; bus.br_disp = 0;
        bus.target = 0; bus.disp_addr = 0; bus.halt = 0;
    endtask

    task automatic modelReset();
        mStep = 0; mWcnt = 0; mHalted = 0; mTimeout = 0;
    endtask

    task automatic modelEdge();
        mTimeout = 0;
        mHalted = bus.halt ? 1 : 0;
        if (!bus.halt) begin
            if (bus.br_wait && !bus.fc) begin
                if (mWcnt == TO - 1) begin
                    mStep = 255; mWcnt = 0; mTimeout = 1;
                end else mWcnt++;
            end else begin
                mWcnt = 0;
                if (bus.br_disp) mStep = bus.disp_addr;
                else if (bus.br_uncnd || (bus.br_cond && bus.cond)) mStep = bus.target;
                else mStep = (mStep + 1) % 256;
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        logic [T_W-1:0] expT;
        modelEdge();
        sb.push_back('{mStep, mHalted, mTimeout});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        expT = '0;
        if (e.halted == 0) expT[e.step] = 1'b1;
        chk("step", int'(bus.step), e.step);
        chk("halted", int'(bus.halted), e.halted);
        chk("timeout", int'(bus.timeout), e.timeout);
        chkT("T", bus.T, expT);
    endtask

    task automatic goTo(logic [7:0] s);
        clearIn();
        bus.br_uncnd = 1; bus.target = s;
        cycle();
        clearIn();
    endtask

    initial begin
        int n;
        vecs[0] = '{0, 0, 1, 1, 0, 0, 8'h20, 8'h40, 8'd8, 8'h40};
        vecs[1] = '{0, 0, 0, 0, 1, 0, 8'h20, 8'h00, 8'd8, 8'd9};
        vecs[2] = '{0, 0, 0, 0, 1, 1, 8'h20, 8'h00, 8'd8, 8'h20};
        vecs[3] = '{0, 0, 0, 1, 0, 0, 8'h77, 8'h00, 8'd8, 8'h77};
        vecs[4] = '{1, 1, 1, 0, 0, 0, 8'h00, 8'h40, 8'd8, 8'h40};
        vecs[5] = '{1, 0, 1, 0, 0, 0, 8'h00, 8'h40, 8'd8, 8'd8};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'd255, 8'd0};
        vecs[7] = '{1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'd3, 8'd4};
        vecs[8] = '{0, 0, 1, 0, 1, 1, 8'h11, 8'h33, 8'd10, 8'h33};

        clearIn();
        modelReset();
        rst = 1;
        #12;
        chk("rst_step", int'(bus.step), 0);
        chkT("rst_T", bus.T, T_W'(1));
        chk("rst_halted", int'(bus.halted), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
        rst = 0;

        repeat (17) cycle();
        chk("run17", int'(bus.step), 17);
        #2 rst = 1;
        #1;
        chk("async_step", int'(bus.step), 0);
        chkT("async_T", bus.T, T_W'(1));
        chk("async_timeout", int'(bus.timeout), 0);
        #2 rst = 0;
        modelReset();
        cycle();
        chk("rel_step", int'(bus.step), 1);

        goTo(8'd0);
        repeat (258) begin
            cycle();
            chk("onehot", int'($onehot(bus.T)), 1);
        end
        chk("wrap_end", int'(bus.step), 2);

        for (int i = 0; i < 9; i++) begin
            goTo(vecs[i].from);
            bus.br_wait = vecs[i].bw; bus.fc = vecs[i].fc;
            bus.br_disp = vecs[i].bd; bus.br_uncnd = vecs[i].bu;
            bus.br_cond = vecs[i].bc; bus.cond = vecs[i].cn;
            bus.target = vecs[i].tgt; bus.disp_addr = vecs[i].dsp;
            cycle();
            chk($sformatf("vec%0d", i), int'(bus.step), int'(vecs[i].exp));
            clearIn();
        end

        goTo(8'd5);
        bus.br_wait = 1; bus.fc = 0;
        repeat (3) cycle();
        chk("wait_hold", int'(bus.step), 5);
        bus.fc = 1;
        cycle();
        chk("wait_done", int'(bus.step), 6);
        clearIn();

        goTo(8'd5);
        bus.br_wait = 1; bus.fc = 0;
        n = 0;
        while (bus.step != 8'd255 && n < 100) begin
            cycle();
            n++;
        end
        chk("to_cycles", n, 64);
        chk("to_pulse", int'(bus.timeout), 1);
        cycle();
        chk("to_clear", int'(bus.timeout), 0);
        chk("to_step", int'(bus.step), 255);
        clearIn();

        goTo(8'd5);
        bus.br_wait = 1; bus.fc = 0;
        repeat (10) cycle();
        bus.halt = 1;
        repeat (20) cycle();
        chk("halt_flag", int'(bus.halted), 1);
        chkT("halt_T", bus.T, '0);
        chk("halt_step", int'(bus.step), 5);
        bus.halt = 0;
        n = 0;
        while (!bus.timeout && n < 100) begin
            cycle();
            n++;
        end
        chk("halt_resume", n, 54);
        clearIn();

        #2 rst = 1;
        #4 rst = 0;
        modelReset();
        bus.br_wait = 1; bus.fc = 0;
        cycle();
        chk("to1_step", int'(bus1.step), 255);
        chk("to1_pulse", int'(bus1.timeout), 1);
        clearIn();
        cycle();
        chk("to1_clear", int'(bus1.timeout), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
